// File: rtl/dff_reg.sv
// Parameterised D register: a STAGES-deep chain of WIDTH-bit flops with a
// synchronous, active-high reset (the port keeps the legacy rst_n name).
module dff_reg #(
   parameter int                 WIDTH       = 1,
   parameter int                 STAGES      = 1,
   parameter logic [WIDTH-1:0]   RESET_VALUE = '0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   if (WIDTH < 1 || WIDTH > 1024) begin : g_bad_width
      $error("dff_reg: WIDTH must be in 1..1024, got %0d", WIDTH);
   end
   if (STAGES < 1 || STAGES > 16) begin : g_bad_stages
      $error("dff_reg: STAGES must be in 1..16, got %0d", STAGES);
   end

   logic [WIDTH-1:0] stage [STAGES];

   // rst_n is active-high; reset wins over data at the same edge.
   always_ff @(posedge clk) begin
      if (rst_n) begin
         for (int i = 0; i < STAGES; i++) begin
            stage[i] <= RESET_VALUE;
         end
      end else begin
         stage[0] <= d;
         for (int i = 1; i < STAGES; i++) begin
            stage[i] <= stage[i-1];
         end
      end
   end

   assign q = stage[STAGES-1];

endmodule

// File: tb/tb_dff_reg.sv
// Directed bench for dff_reg: a default 1-bit instance and an 8-bit,
// 3-stage instance with reset value 8'hA5.
module tb_dff_reg;

   logic       clk;
   logic       rst_a;
   logic [0:0] d_a;
   logic [0:0] q_a;
   logic       rst_b;
   logic [7:0] d_b;
   logic [7:0] q_b;

   int total = 0;
   int bad   = 0;

   dff_reg u_dut_a (
      .clk   (clk),
      .rst_n (rst_a),
      .d     (d_a),
      .q     (q_a)
   );

   dff_reg #(
      .WIDTH       (8),
      .STAGES      (3),
      .RESET_VALUE (8'hA5)
   ) u_dut_b (
      .clk   (clk),
      .rst_n (rst_b),
      .d     (d_b),
      .q     (q_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   // Advance one rising edge and land 1 time unit after it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_a = 1'b1;
      d_a   = 1'b1;
      rst_b = 1'b1;
      d_b   = 8'hFF;

      // Default instance: reset with d=1, then release with d=0.
      step();
      check("a_rst_edge1", {7'd0, q_a}, 8'h00);
      check("b_rst_edge1", q_b, 8'hA5);
      step();
      check("a_rst_edge2", {7'd0, q_a}, 8'h00);
      check("b_rst_edge2", q_b, 8'hA5);
      rst_a = 1'b0;
      d_a   = 1'b0;
      step();
      check("a_release", {7'd0, q_a}, 8'h00);

      // Alternating data, one edge of latency.
      d_a = 1'b1; step(); check("a_data_1", {7'd0, q_a}, 8'h01);
      d_a = 1'b0; step(); check("a_data_0", {7'd0, q_a}, 8'h00);
      d_a = 1'b1; step(); check("a_data_1b", {7'd0, q_a}, 8'h01);

      // Reset raised half a cycle before the edge while q=1, d=1.
      #4;
      rst_a = 1'b1;
      check("a_rst_before_edge", {7'd0, q_a}, 8'h01);
      step();
      check("a_mid_rst", {7'd0, q_a}, 8'h00);
      step();
      check("a_mid_rst_held", {7'd0, q_a}, 8'h00);
      rst_a = 1'b0;
      step();
      check("a_mid_release", {7'd0, q_a}, 8'h01);

      // Reset pulse entirely between two edges must be ignored.
      #2;
      rst_a = 1'b1;
      #2;
      rst_a = 1'b0;
      #1;
      check("a_glitch_between", {7'd0, q_a}, 8'h01);
      d_a = 1'b0;
      step();
      check("a_glitch_edge", {7'd0, q_a}, 8'h00);

      // Three-stage instance: reset value shifts out before data arrives.
      rst_b = 1'b0;
      d_b = 8'h01; step(); check("b_post_rel_1", q_b, 8'hA5);
      d_b = 8'h02; step(); check("b_post_rel_2", q_b, 8'hA5);
      d_b = 8'h03; step(); check("b_data_01", q_b, 8'h01);
      d_b = 8'h00; step(); check("b_data_02", q_b, 8'h02);
      d_b = 8'h00; step(); check("b_data_03", q_b, 8'h03);
      step();               check("b_drain", q_b, 8'h00);

      // Flush of in-flight data: 22, 33 and 44 must never reach q.
      d_b = 8'h11; step(); check("b_fill_1", q_b, 8'h00);
      d_b = 8'h22; step(); check("b_fill_2", q_b, 8'h00);
      d_b = 8'h33; step(); check("b_fill_3", q_b, 8'h11);
      rst_b = 1'b1;
      d_b = 8'h44; step(); check("b_flush", q_b, 8'hA5);
      rst_b = 1'b0;
      d_b = 8'h55; step(); check("b_flush_rel_1", q_b, 8'hA5);
      d_b = 8'h66; step(); check("b_flush_rel_2", q_b, 8'hA5);
      d_b = 8'h77; step(); check("b_flush_data", q_b, 8'h55);
      step();               check("b_flush_data2", q_b, 8'h66);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
